// File: rtl/lsu_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } lsuState_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam int LSU_TIMEOUT = 16;

    typedef enum logic [2:0] {
        LD_W  = 3'd0,
        LD_B  = 3'd1,
        LD_H  = 3'd2,
        LD_BU = 3'd3,
        LD_HU = 3'd4
    } loadKind_e;

    // Collapse the controller's one-hot load-type flags; no flag set means lw.
    function automatic loadKind_e decodeLoad(input logic lb, input logic lh,
                                             input logic lbu, input logic lhu);
        if (lb)  return LD_B;
        if (lh)  return LD_H;
        if (lbu) return LD_BU;
        if (lhu) return LD_HU;
        return LD_W;
    endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Data-bus handshake between the LSU (master) and the memory slave.
interface lsu_mem_stage_if #(
    parameter int XLEN = 32
);
    logic            dbus_req;
    logic            dbus_we;
    logic [XLEN-1:0] dbus_addr;
    logic [3:0]      dbus_wstrb;
    logic [XLEN-1:0] dbus_wdata;
    logic            dbus_gnt;
    logic            dbus_rvalid;
    logic [XLEN-1:0] dbus_rdata;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_wstrb, dbus_wdata,
        input  dbus_gnt, dbus_rvalid, dbus_rdata
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_wstrb, dbus_wdata,
        output dbus_gnt, dbus_rvalid, dbus_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, lane extraction/extension for loads, and
// alignment checking. Purely combinational.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      addrLo,
    input  logic [1:0]      sizeSel,
    input  logic            isStore,
    input  logic [XLEN-1:0] storeData,
    input  logic [1:0]      loadLane,
    input  loadKind_e       loadKind,
    input  logic [XLEN-1:0] loadRaw,
    output logic            misaligned,
    output logic [3:0]      laneStrb,
    output logic [XLEN-1:0] laneData,
    output logic [XLEN-1:0] loadExt
);

    logic [7:0]  pickByte;
    logic [15:0] pickHalf;

    // Reserved size is reported the same way as a misaligned address.
    always_comb begin
        misaligned = 1'b1;
        case (sizeSel)
            SZ_B:    misaligned = 1'b0;
            SZ_H:    misaligned = addrLo[0];
            SZ_W:    misaligned = |addrLo;
            default: misaligned = 1'b1;
        endcase
    end

    // Replicate store data across lanes so the strobes alone pick the bytes.
    always_comb begin
        laneStrb = 4'b0000;
        laneData = storeData;
        if (isStore) begin
            case (sizeSel)
                SZ_B: begin
                    laneStrb = 4'b0001 << addrLo;
                    laneData = {(XLEN/8){storeData[7:0]}};
                end
                SZ_H: begin
                    laneStrb = 4'b0011 << {addrLo[1], 1'b0};
                    laneData = {(XLEN/16){storeData[15:0]}};
                end
                default: laneStrb = 4'b1111;
            endcase
        end
    end

    // Pick the addressed byte/half from the returned word, then extend it.
    always_comb begin
        pickByte = loadRaw[7:0];
        case (loadLane)
            2'd1:    pickByte = loadRaw[15:8];
            2'd2:    pickByte = loadRaw[23:16];
            2'd3:    pickByte = loadRaw[31:24];
            default: ;
        endcase
        pickHalf = loadLane[1] ? loadRaw[31:16] : loadRaw[15:0];
        loadExt  = loadRaw;
        case (loadKind)
            LD_B:    loadExt = {{(XLEN-8){pickByte[7]}}, pickByte};
            LD_BU:   loadExt = {{(XLEN-8){1'b0}}, pickByte};
            LD_H:    loadExt = {{(XLEN-16){pickHalf[15]}}, pickHalf};
            LD_HU:   loadExt = {{(XLEN-16){1'b0}}, pickHalf};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: issues one data-bus access per M-stage
// memory instruction and stalls the pipeline until it completes.
//
// state | meaning
// IDLE  | waiting for an access; misaligned ones go straight to DONE
// REQ   | dbus_req held with registered addr/we/wstrb/wdata until gnt
// RESP  | read granted, waiting for rvalid
// DONE  | stall released, error flags pulse, back to IDLE next cycle
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = LSU_TIMEOUT,
    parameter int CNTW    = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            memreadM,
    input  logic            memwriteM,
    input  logic [1:0]      mem_sizeM,
    input  logic            lbM,
    input  logic            lhM,
    input  logic            lbuM,
    input  logic            lhuM,
    input  logic [XLEN-1:0] aluoutM,
    input  logic [XLEN-1:0] writedataM,
    output logic [XLEN-1:0] readdataM,
    output logic            stallM,
    output logic            bus_errM,
    output logic            misalignM,
    lsu_mem_stage_if.master bus
);

    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(TIMEOUT - 1);

    lsuState_e       state, nextState;
    logic [CNTW-1:0] cnt;
    logic [XLEN-1:0] addrReg, wdataReg, readdataReg;
    logic [1:0]      addrLoReg;
    logic [3:0]      wstrbReg;
    logic            weReg, misFlag, errFlag;
    loadKind_e       ldKindReg;

    logic            access, timeoutHit, inReq;
    logic            startReq, goMis, goErr, capture;
    logic            misaligned;
    logic [3:0]      laneStrb;
    logic [XLEN-1:0] laneData, loadExt;

    assign access     = memreadM | memwriteM;
    assign timeoutHit = (cnt == LAST_CNT);
    assign inReq      = (state == REQ);

    lsu_align #(.XLEN(XLEN)) u_align (
        .addrLo    (aluoutM[1:0]),
        .sizeSel   (mem_sizeM),
        .isStore   (memwriteM),
        .storeData (writedataM),
        .loadLane  (addrLoReg),
        .loadKind  (ldKindReg),
        .loadRaw   (bus.dbus_rdata),
        .misaligned(misaligned),
        .laneStrb  (laneStrb),
        .laneData  (laneData),
        .loadExt   (loadExt)
    );

    // Next state; a gnt/rvalid in the timeout cycle takes priority over the error.
    always_comb begin
        nextState = state;
        startReq  = 1'b0;
        goMis     = 1'b0;
        goErr     = 1'b0;
        capture   = 1'b0;
        unique case (state)
            IDLE: begin
                if (access) begin
                    if (misaligned) begin
                        nextState = DONE;
                        goMis     = 1'b1;
                    end else begin
                        nextState = REQ;
                        startReq  = 1'b1;
                    end
                end
            end
            REQ: begin
                if (bus.dbus_gnt) begin
                    nextState = weReg ? DONE : RESP;
                end else if (timeoutHit) begin
                    nextState = DONE;
                    goErr     = 1'b1;
                end
            end
            RESP: begin
                if (bus.dbus_rvalid) begin
                    nextState = DONE;
                    capture   = 1'b1;
                end else if (timeoutHit) begin
                    nextState = DONE;
                    goErr     = 1'b1;
                end
            end
            DONE: nextState = IDLE;
        endcase
    end

    // State, access registers, timeout counter, error flags and load result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            addrReg     <= '0;
            addrLoReg   <= 2'b00;
            weReg       <= 1'b0;
            wstrbReg    <= 4'b0000;
            wdataReg    <= '0;
            ldKindReg   <= LD_W;
            misFlag     <= 1'b0;
            errFlag     <= 1'b0;
            readdataReg <= '0;
        end else begin
            state <= nextState;
            if (startReq) begin
                cnt       <= '0;
                addrReg   <= {aluoutM[XLEN-1:2], 2'b00};
                addrLoReg <= aluoutM[1:0];
                weReg     <= memwriteM;
                wstrbReg  <= laneStrb;
                wdataReg  <= laneData;
                ldKindReg <= memwriteM ? LD_W : decodeLoad(lbM, lhM, lbuM, lhuM);
            end else if (state == REQ || state == RESP) begin
                cnt <= cnt + 1'b1;
            end
            if (state != DONE && nextState == DONE) begin
                misFlag <= goMis;
                errFlag <= goErr;
            end
            if (capture) begin
                readdataReg <= loadExt;
            end else if (goErr) begin
                readdataReg <= '0;
            end
        end
    end

    // Stall is released in DONE and forced low while reset is applied.
    always_comb begin
        stallM         = access & (state != DONE) & ~reset;
        bus_errM       = (state == DONE) & errFlag;
        misalignM      = (state == DONE) & misFlag;
        readdataM      = readdataReg;
        bus.dbus_req   = inReq;
        bus.dbus_we    = inReq & weReg;
        bus.dbus_addr  = inReq ? addrReg : '0;
        bus.dbus_wstrb = inReq ? wstrbReg : 4'b0000;
        bus.dbus_wdata = (inReq & weReg) ? wdataReg : '0;
    end

endmodule
